// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the pipelined quadrant-split approximate multiplier.
package approx_mul_pkg;
  localparam int MODE_W = 8;
  localparam int OFF_LL = 0;
  localparam int OFF_LH = 2;
  localparam int OFF_HL = 4;
  localparam int OFF_HH = 6;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_T2    = 2'd1,
    MODE_T4    = 2'd2,
    MODE_T6    = 2'd3
  } quad_mode_e;

  function automatic quad_mode_e mode_field(logic [MODE_W-1:0] m, int off);
    return quad_mode_e'(m[off +: 2]);
  endfunction
endpackage

// File: rtl/approx_mul_if.sv
// Operand/product stream plus mode-register access for approx_mul_pipe.
interface approx_mul_if #(parameter int W = 8);
  import approx_mul_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              cfg_we;
  logic [MODE_W-1:0] cfg_mode;
  logic [MODE_W-1:0] mode_q;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    out_prod;

  modport slave (
    input  in_valid, in_a, in_b, cfg_we, cfg_mode, out_ready,
    output in_ready, out_valid, out_prod, mode_q
  );
  modport master (
    output in_valid, in_a, in_b, cfg_we, cfg_mode, out_ready,
    input  in_ready, out_valid, out_prod, mode_q
  );
endinterface

// File: rtl/approx_mul_pipe_quad.sv
// One HWxHW quadrant multiply; mode m zeroes the low 2*m product bits,
// so the result can only fall below the exact quadrant product.
module approx_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int HW = 4
) (
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  input  quad_mode_e      mode,
  output logic [2*HW-1:0] p
);
  logic [2*HW-1:0] full;

  assign full = {{HW{1'b0}}, a} * {{HW{1'b0}}, b};

  always_comb begin
    p = full;
    for (int i = 0; i < 2*HW; i++)
      if (i < 2*int'(mode)) p[i] = 1'b0;
  end
endmodule

// File: rtl/approx_mul_pipe.sv
// 3-stage approximate multiplier: operand/mode capture, truncated quadrant
// products, shift-add recombine. APPROX_MUL_ERR_MON_EN adds err_abs/err_cnt.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int              W        = 8,
  parameter logic [MODE_W-1:0] MODE_RST = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
`ifdef APPROX_MUL_ERR_MON_EN
  output logic [2*W-1:0] err_abs,
  output logic [31:0]    err_cnt,
`endif
  approx_mul_if.slave  bus
);
  localparam int HW     = W/2;
  localparam int PW     = 2*W;
  localparam int STAGES = 3;

  logic                  en;
  logic [STAGES:1]       vld_pipe;
  logic [MODE_W-1:0]     mode_r;
  logic [W-1:0]          a1, b1;
  logic [MODE_W-1:0]     mode1;
  logic [3:0][W-1:0]     qp_c, qp;
  logic [PW-1:0]         sum, prod;

  // An empty output slot never blocks, so bubbles drain through it.
  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_prod  = prod;
  assign bus.mode_q    = mode_r;

  always_ff @(posedge clk) begin
    if (rst)             mode_r <= MODE_RST;
    else if (bus.cfg_we) mode_r <= bus.cfg_mode;
  end

  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // mode1 captures mode_r before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (en) begin
      a1    <= bus.in_a;
      b1    <= bus.in_b;
      mode1 <= mode_r;
      qp    <= qp_c;
    end
  end

  // Quadrant index q: 0=LL, 1=LH, 2=HL, 3=HH; bit1 picks A half, bit0 picks B half.
  for (genvar q = 0; q < 4; q++) begin : g_quad
    localparam int OFF = (q == 0) ? OFF_LL : (q == 1) ? OFF_LH : (q == 2) ? OFF_HL : OFF_HH;
    logic [HW-1:0] qa, qb;
    assign qa = (q >= 2)    ? a1[W-1:HW] : a1[HW-1:0];
    assign qb = (q % 2 == 1) ? b1[W-1:HW] : b1[HW-1:0];
    approx_quad_mul #(.HW(HW)) u_quad (
      .a    (qa),
      .b    (qb),
      .mode (mode_field(mode1, OFF)),
      .p    (qp_c[q])
    );
  end

  assign sum = (PW'(qp[3]) << W) + ((PW'(qp[2]) + PW'(qp[1])) << HW) + PW'(qp[0]);

  always_ff @(posedge clk) begin
    if (rst)     prod <= '0;
    else if (en) prod <= sum;
  end

`ifdef APPROX_MUL_ERR_MON_EN
  logic [PW-1:0] exact2;
  logic [PW-1:0] err_r;
  logic [31:0]   cnt_r;

  always_ff @(posedge clk) begin
    if (en) exact2 <= PW'(a1) * PW'(b1);
  end

  always_ff @(posedge clk) begin
    if (rst)     err_r <= '0;
    else if (en) err_r <= exact2 - sum;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_r <= '0;
    else if (vld_pipe[STAGES] && bus.out_ready && err_r != '0 && cnt_r != '1)
      cnt_r <= cnt_r + 32'd1;
  end

  assign err_abs = err_r;
  assign err_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_approx_mul_pipe.sv
// Randomized + directed bench for approx_mul_pipe against an arithmetic reference model.
module tb_approx_mul_pipe;
  import approx_mul_pkg::*;
  localparam int              W        = 8;
  localparam logic [7:0]      MODE_RST = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_mul_if #(.W(W)) bus();
`ifdef APPROX_MUL_ERR_MON_EN
  logic [2*W-1:0] err_abs;
  logic [31:0]    err_cnt;
`endif

  approx_mul_pipe #(.W(W), .MODE_RST(MODE_RST)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef APPROX_MUL_ERR_MON_EN
    .err_abs (err_abs),
    .err_cnt (err_cnt),
`endif
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Quadrant value with the low 2*m bits dropped, from plain arithmetic.
  function automatic longint quad(input longint x, input longint y, input int m);
    longint p;
    p = x * y;
    return p - (p % (longint'(1) << (2*m)));
  endfunction

  function automatic longint ref_prod(input longint a, input longint b, input logic [7:0] m);
    longint base, ah, al, bh, bl;
    base = longint'(1) << (W/2);
    ah = a / base; al = a % base;
    bh = b / base; bl = b % base;
    return quad(ah, bh, int'(m[7:6])) * base * base
         + (quad(ah, bl, int'(m[5:4])) + quad(al, bh, int'(m[3:2]))) * base
         + quad(al, bl, int'(m[1:0]));
  endfunction

  typedef struct { longint prod; longint exact; int cyc; } exp_t;
  exp_t       sb[$];
  longint     log_q[$];
  int         cyc = 0;
  int         last_lat = 0;
  logic [7:0] model_mode = MODE_RST;
  longint     model_errs = 0;
  longint     last_err = 0;
  bit         stall_prev = 0;
  logic [15:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: acceptance and output handshakes are sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      model_mode = MODE_RST;
      model_errs = 0;
      stall_prev = 0;
    end else begin
      if (bus.out_valid) begin
        if (stall_prev) check("stall_hold", 64'(bus.out_prod), 64'(held));
        if (sb.size() == 0) check("stale_out", 64'(bus.out_valid), 64'(0));
        else if (bus.out_ready) begin
          e = sb.pop_front();
          check("prod", 64'(bus.out_prod), 64'(e.prod));
          last_lat = cyc - e.cyc;
          log_q.push_back(longint'(bus.out_prod));
`ifdef APPROX_MUL_ERR_MON_EN
          check("err_abs", 64'(err_abs), 64'(e.exact - e.prod));
          check("err_cnt", 64'(err_cnt), 64'(model_errs));
          last_err = longint'(err_abs);
          if (e.exact != e.prod && model_errs < 64'hFFFF_FFFF) model_errs++;
`endif
        end else
          check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        stall_prev = !bus.out_ready;
        held = bus.out_prod;
      end else begin
        if (stall_prev) check("stall_valid", 64'(bus.out_valid), 64'(1));
        stall_prev = 0;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{ref_prod(64'(bus.in_a), 64'(bus.in_b), model_mode),
                       64'(bus.in_a) * 64'(bus.in_b), cyc});
      if (bus.cfg_we) model_mode = bus.cfg_mode;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic cfg(input logic [7:0] m);
    bus.cfg_we = 1'b1; bus.cfg_mode = m;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  bit done = 0;

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.cfg_we = 1'b0; bus.cfg_mode = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_prod", 64'(bus.out_prod), 64'(0));
    check("rst_mode_q", 64'(bus.mode_q), 64'(MODE_RST));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef APPROX_MUL_ERR_MON_EN
    check("rst_err_abs", 64'(err_abs), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
    rst = 1'b0;

    // exact path and latency
    send(8'hFF, 8'hFF); idle(); drain();
    check("exact_prod", 64'(log_q[$]), 64'h FE01);
    check("exact_lat", 64'(last_lat), 64'(3));
    check("exact_mode_q", 64'(bus.mode_q), 64'(0));

    // full truncation
    cfg(8'hFF);
    check("cfg_mode_q", 64'(bus.mode_q), 64'hFF);
    send(8'hFF, 8'hFF); idle(); drain();
    check("trunc_prod", 64'(log_q[$]), 64'h D8C0);
`ifdef APPROX_MUL_ERR_MON_EN
    check("trunc_err_abs", 64'(last_err), 64'h2541);
    check("trunc_err_cnt", 64'(err_cnt), 64'(1));
`endif

    // single quadrant
    cfg(8'h01);
    send(8'h03, 8'h03); send(8'h03, 8'h30); idle(); drain();
    check("ll_trunc", 64'(log_q[$-1]), 64'h0008);
    check("lh_exact", 64'(log_q[$]), 64'h0090);

    // mode snapshot: write lands in the accepting cycle
    cfg(8'h00);
    bus.cfg_we = 1'b1; bus.cfg_mode = 8'hFF;
    send(8'hFF, 8'hFF);
    bus.cfg_we = 1'b0;
    send(8'hFF, 8'hFF); idle(); drain();
    check("snap_first", 64'(log_q[$-1]), 64'hFE01);
    check("snap_second", 64'(log_q[$]), 64'hD8C0);

    // backpressure
    cfg(8'h00);
    log_q.delete();
    fork
      begin
        for (int i = 1; i <= 5; i++) send(8'(i), 8'(i));
        idle();
      end
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(log_q.size()), 64'(5));
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      check("bp_order", 64'(log_q[i]), 64'((i+1)*(i+1)));

    // randomized traffic with random stalls and mode writes
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin idle(); tick(); end
          send(8'($urandom_range(255)), 8'($urandom_range(255)));
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin bus.out_ready = ($urandom_range(3) != 0); tick(); end
        bus.out_ready = 1'b1;
      end
      begin
        while (!done) begin
          bus.cfg_we = ($urandom_range(7) == 0);
          bus.cfg_mode = 8'($urandom_range(255));
          tick();
        end
        bus.cfg_we = 1'b0;
      end
    join
    drain();

    // reset with three transactions in flight
    cfg(8'h55);
    send(8'd1, 8'd2); send(8'd3, 8'd4); send(8'd5, 8'd6); idle();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_out_prod", 64'(bus.out_prod), 64'(0));
    check("midrst_mode_q", 64'(bus.mode_q), 64'(MODE_RST));
`ifdef APPROX_MUL_ERR_MON_EN
    check("midrst_err_cnt", 64'(err_cnt), 64'(0));
`endif
    rst = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 quadrant-split approximate multiplier.
- Splits W-bit unsigned operands into high and low halves and forms four (W/2)x(W/2) quadrant products HH, HL, LH and LL.
- Each quadrant has its own run-time approximation level; the quadrants are recombined by a shift-add stage.
- valid/ready streaming in and out, 3-cycle latency; sits in datapaths that trade accuracy for area and power.

Parameters:
- W, 8, operand width; even, >= 4; product width is 2W.
- MODE_RST, 8'h00, reset value of the quadrant mode register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- cfg_we  in  1  write enable for the mode register.
- cfg_mode  in  8  quadrant modes: [1:0] LL, [3:2] LH, [5:4] HL, [7:6] HH.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- out_prod  out  2W  approximate product.
- mode_q  out  8  current mode register value.

Behaviour:
- Clocking: one clock `clk`; `rst` is synchronous and active-high. On rst: all stage valids = 0; out_valid = 0; out_prod = 0; mode_q = MODE_RST. Pipeline data contents are don't-care except out_prod.
- Global advance: en = !out_valid || out_ready. in_ready = en, combinational.
- Transaction acceptance: an operand pair is accepted when in_valid && in_ready.
- Stage 1 (on en): register a, b, valid and the mode snapshot. The snapshot is mode_q before any same-cycle cfg_we write, so a write in the accepting cycle affects only later transactions.
- Stage 2 (on en): register four (W-bit) quadrant products, then apply the mode. Mode m in {0,1,2,3} forces the low 2*m bits of that quadrant product to 0. Example: m=0 exact, m=3 clears bits [5:0].
- Stage 3 (on en): out_prod = (HH<<W) + ((HL+LH)<<(W/2)) + LL, computed at full 2W width with no overflow; out_valid = stage-2 valid.
- Latency: exactly 3 cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 product/cycle.
- Backpressure: while out_valid && !out_ready, every stage holds. out_prod and out_valid stay stable, in_ready = 0.
- Bubbles: bubbles do not collapse, except that an invalid output slot never blocks.
- cfg_we: writes cfg_mode into mode_q every cycle it is asserted, independent of the handshake and including during stalls.
- Reset mid-operation: in-flight transactions are discarded; no out_valid appears afterwards.
- Error sign: the approximate product never exceeds the exact product.

Optional Feature:
- Macro: APPROX_MUL_ERR_MON_EN.
- With the macro defined, two extra ports are added:
  - err_abs  out  2W: exact minus approximate product, aligned with out_prod. It is computed through a parallel exact pipeline with identical staging; reset value 0.
  - err_cnt  out  32: increments on each output handshake where err_abs != 0; saturates at 32'hFFFFFFFF; cleared by rst.
- Without the macro: neither port nor the exact pipeline exists. Behaviour is otherwise identical.

Decomposition:
- Shared package `approx_mul_pkg`:
  - quadrant mode typedef (2-bit enum MODE_EXACT, MODE_T2, MODE_T4, MODE_T6);
  - mode-field bit offsets LL/LH/HL/HH;
  - mode-register width constant 8.
- One sub-module `approx_quad_mul` (parameter HW = W/2): combinational HWxHW multiply plus low-bit truncation by mode. It is instantiated four times in stage 2.

Test Plan:
- Exact path: W=8, reset, stream a=8'hFF,b=8'hFF with out_ready=1. Required: out_prod = 16'hFE01 exactly 3 cycles after acceptance; mode_q = 8'h00.
- Full truncation: cfg_mode=8'hFF, then a=8'hFF,b=8'hFF. Required: each quadrant = 8'hC0, out_prod = 16'hD8C0. With APPROX_MUL_ERR_MON_EN: err_abs = 16'h2541, err_cnt = 1.
- Single quadrant: cfg_mode=8'h01 (LL truncates 2 bits), a=8'h03,b=8'h03. Required: out_prod = 16'h0008. With b=8'h30: out_prod = 16'h0090, LL unaffected.
- Mode snapshot: cfg_we with 8'hFF in the same cycle as accepting a=b=8'hFF, then a second identical pair. Required: first product 16'hFE01, second 16'hD8C0.
- Backpressure: stream 5 pairs (i,i) for i=1..5 with out_ready low for 4 cycles after the first out_valid. Required: in_ready=0 and out_prod held during the stall; outputs 1,4,9,16,25 in order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 transactions in flight. Required: out_valid=0, out_prod=0, mode_q=MODE_RST next cycle, and no stale products emitted.
